mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter between the instruction cache and the data cache, in front of the single shared main memory. Cache misses (line fills) and dirty-line writebacks arrive as whole-line requests. The block grants one requester at a time using round-robin, then sequences the line as WORDS word beats to memory. It also tracks read-return latency and routes returned words back to the owning cache.

## Interface
Parameters:
- WORDS, 4: words per cache line; power of two, 2..8.
- LATENCY, 2: memory read latency in cycles, from accepted read beat to mem_data_out valid; 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache line read request; held until i_gnt.
- i_addr  in  16  I-cache line byte address; bits [log2(WORDS*2)-1:0] ignored and forced to 0.
- i_gnt  out  1  one-cycle pulse: I request accepted, address captured.
- i_rd_valid  out  1  I return word valid.
- i_rd_data  out  16  I return word.
- i_word  out  log2(WORDS)  index of the returned word.
- i_done  out  1  pulse with the last I return word.
- d_req  in  1  D-cache line request; held until d_gnt.
- d_wr  in  1  D request is a writeback (1) or a fill (0); sampled with d_req.
- d_addr  in  16  D-cache line byte address; same alignment rule as i_addr.
- d_wr_data  in  16  writeback word selected by d_wr_word; combinational from the cache.
- d_wr_word  out  log2(WORDS)  index of the writeback word currently being issued.
- d_gnt, d_rd_valid, d_rd_data, d_word, d_done  out  1/1/16/log2(WORDS)/1  same meaning as the I-side outputs.
- mem_rd, mem_wr  out  1  memory beat strobes; mutually exclusive.
- mem_addr  out  16  beat address = base + 2*beat.
- mem_data_in  out  16  write data; equals d_wr_data during a write beat.
- mem_stall  in  1  memory refuses the beat this cycle; the beat is held.
- mem_data_out  in  16  read data, valid LATENCY cycles after an accepted read beat.
- busy  out  1  state != IDLE.
- owner  out  1  0 = I, 1 = D; valid while busy.

## Operation
- State machine IDLE, ISSUE, DRAIN.
- IDLE, with any request: arbitrate and capture owner, base address and op. Next state is ISSUE.
- Arbitration: if only one requester is asking, it wins. If both ask, the winner is the one not granted last. The last-grant pointer resets to D, so I wins the first tie.
- ISSUE, first cycle: x_gnt pulses.
  - Each cycle, drive one beat: mem_rd or mem_wr, with mem_addr = base + 2*issue_cnt.
  - A beat is accepted when its strobe is high and mem_stall is 0. issue_cnt increments only on accept.
  - While mem_stall is 1, all mem_* outputs hold steady.
- Last beat accepted, read: go to DRAIN.
- Last beat accepted, write: x_done pulses that cycle; go to IDLE.
- Return tracking: a LATENCY-deep shift register of {valid, word index}, loaded by each accepted read beat.
  - When the tail is valid, the owner's x_rd_valid, x_rd_data (= mem_data_out) and x_word are driven combinationally.
  - Returns can overlap the ISSUE state.
- DRAIN: on the tail entry with index WORDS-1, x_done pulses with that x_rd_valid; go to IDLE.
- Non-owner outputs are 0 at all times.
- A request dropped before its grant is legal and is simply not served.
- Requests that arrive while busy wait. Inputs are re-sampled only in IDLE.
- Reset (any time, including mid-burst):
  - state IDLE, counters 0, shift register cleared, pointer D.
  - All outputs 0.
  - No done pulse.
  - The aborted burst is lost.

## Timing
- Request seen in IDLE at cycle t: grant and first beat at t+1.
- Read, no stalls: words at t+1+LATENCY .. t+WORDS+LATENCY; done with the last word. Back in IDLE at t+WORDS+LATENCY+1.
- Write, no stalls: beats t+1..t+WORDS; done at t+WORDS; IDLE at t+WORDS+1.
- Each stall cycle adds exactly one cycle.
- There is at least one IDLE cycle between transactions, so back-to-back grants are 1 cycle + burst length apart.
- mem_rd, mem_wr, mem_addr and the grants are functions of registered state only. They never depend combinationally on mem_stall.
- Address arithmetic is 16-bit modulo; line base 0xFFF8 issues beats 0xFFF8..0xFFFE with no wrap into 0.

## Structure
- Shared package (mem_arb_pkg):
  - state encoding constants for IDLE, ISSUE, DRAIN
  - owner constants OWN_I and OWN_D
  - the WORDS and LATENCY defaults
- Sub-module mem_arb_rr: the 2-way round-robin picker, holding the last-grant pointer. Its update_en input is pulsed with the grant.
- The latency shift register stays inline.

## Test plan
- Reset, then i_req with i_addr=0x0104: i_gnt at t+1 and mem_addr 0x0100, 0x0102, 0x0104, 0x0106. With memory returning 0xA0..0xA3, i_word is 0..3; i_done coincides with word 3 at t+6 (LATENCY=2).
- i_req and d_req high in the same cycle: I granted first, D at the next IDLE. A second simultaneous pair: D granted first.
- D writeback to 0x2000 with d_wr_data = 0x1110+index: mem_wr beats carry 0x1110..0x1113. d_done at t+4; no d_rd_valid.
- mem_stall high for 3 cycles on beat 2 of an I fill: mem_addr held at base+4; done is 3 cycles late; data order intact.
- rst low in the middle of DRAIN: all outputs 0 immediately, no i_done. After release, a fresh d_req is served normally.
- Line base 0xFFF8: beats end at 0xFFFE. A request dropped before its grant issues no beats.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: state encoding,
// owner identifiers and default line/latency geometry.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arbState_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int WORDS_DEF   = 4;
  localparam int LATENCY_DEF = 2;
endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; remembers who won last and favours the other on a tie.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic reqI,
  input  logic reqD,
  input  logic update_en,
  output logic pick
);
  logic lastGnt;

  assign pick = (reqI && reqD) ? ~lastGnt : reqD;

  // Pointer starts at D so the first tie goes to I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lastGnt <= OWN_D;
    else if (update_en) lastGnt <= pick;
  end
endmodule

// File: rtl/mem_arbiter.sv
// I/D-cache line arbiter: grants one requester, issues WORDS beats to memory,
// and steers read returns (after LATENCY cycles) back to the owning cache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS   = WORDS_DEF,
  parameter int LATENCY = LATENCY_DEF,
  localparam int IW     = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [15:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rd_valid,
  output logic [15:0]   i_rd_data,
  output logic [IW-1:0] i_word,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [15:0]   d_addr,
  input  logic [15:0]   d_wr_data,
  output logic [IW-1:0] d_wr_word,
  output logic          d_gnt,
  output logic          d_rd_valid,
  output logic [15:0]   d_rd_data,
  output logic [IW-1:0] d_word,
  output logic          d_done,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_data_in,
  input  logic          mem_stall,
  input  logic [15:0]   mem_data_out,
  output logic          busy,
  output logic          owner
);
  localparam logic [15:0] ALIGN = ~16'(WORDS * 2 - 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  arbState_e state;
  logic ownerR, opWr, gntR;
  logic [15:0] base;
  logic [IW-1:0] issueCnt;
  logic [LATENCY:1] vldPipe;
  logic [LATENCY:1][IW-1:0] idxPipe;
  logic pick, anyReq, issuing, accept, lastBeat, tailVld, tailLast, wrDone, rdDone;
  logic ownI, ownD;

  mem_arb_rr uRr (
    .clk      (clk),
    .rst_n    (rst),
    .reqI     (i_req),
    .reqD     (d_req),
    .update_en(state == IDLE && anyReq),
    .pick     (pick)
  );

  assign anyReq   = i_req | d_req;
  assign issuing  = state == ISSUE;
  assign ownI     = ownerR == OWN_I;
  assign ownD     = ownerR == OWN_D;

  // Beat strobes and address come from registered state only, so a stall simply holds them.
  assign mem_rd      = issuing & ~opWr;
  assign mem_wr      = issuing & opWr;
  assign mem_addr    = issuing ? base + {{(15 - IW){1'b0}}, issueCnt, 1'b0} : '0;
  assign mem_data_in = mem_wr ? d_wr_data : '0;
  assign d_wr_word   = mem_wr ? issueCnt : '0;

  assign accept   = (mem_rd | mem_wr) & ~mem_stall;
  assign lastBeat = issueCnt == LAST;
  assign tailVld  = vldPipe[LATENCY];
  assign tailLast = tailVld & (idxPipe[LATENCY] == LAST);
  assign wrDone   = mem_wr & accept & lastBeat;
  assign rdDone   = (state == DRAIN) & tailLast;

  assign i_gnt      = gntR & ownI;
  assign d_gnt      = gntR & ownD;
  assign i_rd_valid = tailVld & ownI;
  assign d_rd_valid = tailVld & ownD;
  assign i_rd_data  = i_rd_valid ? mem_data_out : '0;
  assign d_rd_data  = d_rd_valid ? mem_data_out : '0;
  assign i_word     = i_rd_valid ? idxPipe[LATENCY] : '0;
  assign d_word     = d_rd_valid ? idxPipe[LATENCY] : '0;
  assign i_done     = rdDone & ownI;
  assign d_done     = (rdDone | wrDone) & ownD;
  assign busy       = state != IDLE;
  assign owner      = ownerR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ownerR   <= OWN_I;
      opWr     <= 1'b0;
      gntR     <= 1'b0;
      base     <= '0;
      issueCnt <= '0;
    end else begin
      gntR <= 1'b0;
      case (state)
        IDLE: if (anyReq) begin
          ownerR   <= pick;
          opWr     <= pick & d_wr;
          base     <= (pick ? d_addr : i_addr) & ALIGN;
          gntR     <= 1'b1;
          issueCnt <= '0;
          state    <= ISSUE;
        end
        ISSUE: if (accept) begin
          issueCnt <= lastBeat ? '0 : issueCnt + IW'(1);
          if (lastBeat) state <= opWr ? IDLE : DRAIN;
        end
        DRAIN: if (tailLast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return tracker: each accepted read beat emerges at the tail LATENCY cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe <= '0;
      idxPipe <= '0;
    end else begin
      vldPipe[1] <= mem_rd & accept;
      idxPipe[1] <= issueCnt;
      for (int k = 2; k <= LATENCY; k++) begin
        vldPipe[k] <= vldPipe[k-1];
        idxPipe[k] <= idxPipe[k-1];
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model and a behavioural memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int W  = 4;
  localparam int L  = 2;
  localparam int IW = $clog2(W);

  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 0, d_req = 0, d_wr = 0, mem_stall = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wr_data, mem_data_out = 0;
  logic i_gnt, i_rd_valid, i_done, d_gnt, d_rd_valid, d_done;
  logic mem_rd, mem_wr, busy, owner;
  logic [15:0] i_rd_data, d_rd_data, mem_addr, mem_data_in;
  logic [IW-1:0] i_word, d_word, d_wr_word;

  int nChecks = 0, nErrors = 0;
  logic [15:0] memArr [0:32767];
  logic [15:0] dq [1:L];
  logic [15:0] wrPat = 0;
  bit lastD = 1'b1;

  mem_arbiter #(.WORDS(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rd_valid(i_rd_valid),
    .i_rd_data(i_rd_data), .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_wr_word(d_wr_word), .d_gnt(d_gnt), .d_rd_valid(d_rd_valid),
    .d_rd_data(d_rd_data), .d_word(d_word), .d_done(d_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_stall(mem_stall), .mem_data_out(mem_data_out), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Cache side: writeback word is a fixed pattern plus its index.
  assign d_wr_data = wrPat + 16'(d_wr_word);

  // Behavioural memory with fixed read latency.
  always @(posedge clk) begin
    if (mem_wr && !mem_stall) memArr[mem_addr[15:1]] = mem_data_in;
    for (int k = L; k > 1; k--) dq[k] = dq[k-1];
    dq[1] = (mem_rd && !mem_stall) ? memArr[mem_addr[15:1]] : 16'h0;
    mem_data_out = dq[L];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    i_req = 0; d_req = 0; mem_stall = 0; rst = 0; lastD = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic fillLine(input logic [15:0] addr);
    logic [14:0] b;
    b = addr[15:1] & ~15'(W - 1);
    for (int j = 0; j < W; j++) memArr[15'(b + 15'(j))] = 16'($urandom);
  endtask

  // Serve one granted line transaction and check it end to end.
  task automatic serve(input bit own, input bit wr, input logic [15:0] addr,
                       input int stallAt, input int stallLen, input int expWait);
    logic [15:0] base;
    logic [15:0] expD [W];
    int beat, stalls, nWords, waited, doneK, expDone;
    bit quietBad, gotGnt, rv, dn;
    base = addr & ~16'(2 * W - 1);
    for (int j = 0; j < W; j++) expD[j] = memArr[15'(base[15:1] + 15'(j))];
    waited = 0; gotGnt = 0;
    while (!gotGnt && waited < 60) begin
      @(negedge clk); mem_stall = 0; #1; waited++;
      gotGnt = i_gnt | d_gnt;
    end
    chk("gntSeen", 32'(gotGnt), 1);
    if (!gotGnt) return;
    chk("gntWait", waited, expWait);
    chk("gntOwner", {30'd0, i_gnt, d_gnt}, own ? 32'd1 : 32'd2);
    chk("ownerOut", {30'd0, busy, owner}, {30'd0, 1'b1, own});
    if (own) d_req = 0; else i_req = 0;
    lastD = own;
    beat = 0; stalls = 0; nWords = 0; doneK = -1; quietBad = 0;
    for (int k = 0; k < 60 && doneK < 0; k++) begin
      if (k > 0) begin
        @(negedge clk);
        mem_stall = (beat == stallAt) && (stalls < stallLen);
        #1;
      end
      if (beat < W) begin
        chk("strobe", {30'd0, mem_rd, mem_wr}, wr ? 32'd1 : 32'd2);
        chk("addr", 32'(mem_addr), 32'(base + 16'(2 * beat)));
        if (wr) chk("wdata", 32'(mem_data_in), 32'(wrPat + 16'(beat)));
        if (mem_stall) stalls++; else beat++;
      end else chk("noStrobe", {30'd0, mem_rd, mem_wr}, 0);
      rv = own ? d_rd_valid : i_rd_valid;
      if (rv) begin
        chk("rdWord", 32'(own ? d_word : i_word), nWords);
        chk("rdData", 32'(own ? d_rd_data : i_rd_data), (nWords < W) ? 32'(expD[nWords]) : 32'hDEAD);
        nWords++;
      end
      dn = own ? d_done : i_done;
      if (dn) doneK = k;
      if (own ? (i_rd_valid | i_done | i_gnt | (|i_rd_data) | (|i_word))
              : (d_rd_valid | d_done | d_gnt | (|d_rd_data) | (|d_word))) quietBad = 1;
    end
    expDone = (wr ? W - 1 : W + L - 1) + stallLen;
    chk("doneCycle", doneK, expDone);
    chk("nWords", nWords, wr ? 0 : W);
    chk("beats", beat, W);
    chk("quiet", 32'(quietBad), 0);
    @(negedge clk); mem_stall = 0; #1;
    chk("idleAfter", 32'(busy), 0);
    if (wr)
      for (int j = 0; j < W; j++)
        chk("memWr", 32'(memArr[15'(base[15:1] + 15'(j))]), 32'(wrPat + 16'(j)));
  endtask

  // Both request in the same cycle; the model picks the one not granted last.
  task automatic pair(input logic [15:0] ia, input logic [15:0] da, input bit dw,
                      input int stallAt, input int stallLen);
    bit first;
    fillLine(ia); fillLine(da);
    @(negedge clk);
    i_addr = ia; d_addr = da; d_wr = dw; i_req = 1; d_req = 1;
    first = lastD ? 1'b0 : 1'b1;
    if (first) begin
      serve(1, dw, da, stallAt, stallLen, 1);
      serve(0, 0, ia, 1, 0, 1);
    end else begin
      serve(0, 0, ia, stallAt, stallLen, 1);
      serve(1, dw, da, 1, 0, 1);
    end
  endtask

  initial begin
    int nBad, mode;
    bit doneSeen, dw;
    logic [15:0] ia, da;
    for (int j = 0; j < 32768; j++) memArr[j] = 16'(j * 3);
    #2 rst = 0;
    #1;
    chk("rstCtl", {19'd0, busy, owner, mem_rd, mem_wr, i_gnt, d_gnt, i_rd_valid, d_rd_valid,
                   i_done, d_done, i_word, d_word}, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    // Directed line fill with known data.
    for (int j = 0; j < W; j++) memArr[15'h0080 + 15'(j)] = 16'hA0 + 16'(j);
    @(negedge clk); i_addr = 16'h0104; i_req = 1;
    serve(0, 0, 16'h0104, 1, 0, 1);

    // Ties from a fresh pointer, then again.
    resetDut();
    pair(16'h0200, 16'h0300, 1'b0, 1, 0);
    pair(16'h0240, 16'h0340, 1'b0, 1, 0);

    // Writeback.
    wrPat = 16'h1110;
    @(negedge clk); d_addr = 16'h2000; d_wr = 1; d_req = 1;
    serve(1, 1, 16'h2000, 1, 0, 1);

    // Three stall cycles on beat 2 of a fill.
    fillLine(16'h0800);
    @(negedge clk); i_addr = 16'h0800; i_req = 1;
    serve(0, 0, 16'h0800, 2, 3, 1);

    // Top-of-memory line.
    fillLine(16'hFFF8);
    @(negedge clk); i_addr = 16'hFFFB; i_req = 1;
    serve(0, 0, 16'hFFFB, 1, 0, 1);

    // Request raised and dropped while busy is never served.
    wrPat = 16'h7700;
    @(negedge clk); d_addr = 16'h0500; d_wr = 1; d_req = 1;
    fork
      serve(1, 1, 16'h0500, 1, 0, 1);
      begin
        repeat (2) @(negedge clk);
        i_addr = 16'h0600; i_req = 1;
        @(negedge clk); i_req = 0;
      end
    join
    nBad = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (busy | mem_rd | mem_wr) nBad++;
    end
    chk("droppedNoBeats", nBad, 0);

    // Reset in the middle of DRAIN.
    @(negedge clk); i_addr = 16'h0300; i_req = 1; d_wr = 0;
    @(negedge clk); #1; chk("midGnt", 32'(i_gnt), 1); i_req = 0;
    repeat (W) @(negedge clk);
    #1; chk("midReturning", {30'd0, busy, i_rd_valid}, 3);
    rst = 0; #1;
    chk("rstMidCtl", {19'd0, busy, owner, mem_rd, mem_wr, i_gnt, d_gnt, i_rd_valid, d_rd_valid,
                      i_done, d_done, i_word, d_word}, 0);
    chk("rstMidAddr", {mem_addr, mem_data_in}, 0);
    chk("rstMidData", {i_rd_data, d_rd_data}, 0);
    doneSeen = 0;
    repeat (2) begin
      @(negedge clk); #1;
      doneSeen |= i_done | d_done;
    end
    chk("noDoneInRst", 32'(doneSeen), 0);
    @(negedge clk); rst = 1; lastD = 1'b1;
    fillLine(16'h0400);
    @(negedge clk); d_addr = 16'h0400; d_wr = 0; d_req = 1;
    serve(1, 0, 16'h0400, 2, 1, 1);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 2);
      ia = 16'($urandom); da = 16'($urandom); dw = 1'($urandom_range(0, 1));
      wrPat = 16'($urandom);
      if (mode == 2) pair(ia, da, dw, $urandom_range(1, W - 1), $urandom_range(0, 3));
      else if (mode == 1) begin
        fillLine(da);
        @(negedge clk); d_addr = da; d_wr = dw; d_req = 1;
        serve(1, dw, da, $urandom_range(1, W - 1), $urandom_range(0, 3), 1);
      end else begin
        fillLine(ia);
        @(negedge clk); i_addr = ia; i_req = 1;
        serve(0, 0, ia, $urandom_range(1, W - 1), $urandom_range(0, 3), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
